// File: rtl/reg_file_rd.sv
// Integer register file, read side: 32 x XLEN storage, two registered read
// ports, one write-back port and a per-register pending-write scoreboard that
// stalls decode while a source operand is still in flight.
// Optional feature: define RF_WRITE_BYPASS_EN to forward same-cycle write-back
// data to the read ports and release the stall in the write-back cycle.
module reg_file_rd #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rd_en,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rd_valid,
    output logic            stall,
    input  logic            sb_set,
    input  logic [4:0]      sb_addr,
    input  logic            wr_en,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    localparam int unsigned NREG = 32;

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs1_data_d;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] rs2_data_d;
    logic            rd_valid_q;
    logic            rd_valid_d;

    logic            wr_hit;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            accept;

    assign wr_hit = wr_en && (wr_addr != 5'd0);

    // Storage and scoreboard update; a same-cycle set beats the write-back clear
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_hit) begin
            regs_d[wr_addr] = wr_data;
            busy_d[wr_addr] = 1'b0;
        end
        if (sb_set && (sb_addr != 5'd0)) begin
            busy_d[sb_addr] = 1'b1;
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    // Operand selection and stall; looks only at current busy, never at sb_set
    always_comb begin
        op1   = regs_q[rs1_addr];
        op2   = regs_q[rs2_addr];
        stall = 1'b0;
`ifdef RF_WRITE_BYPASS_EN
        if (wr_hit && (wr_addr == rs1_addr)) begin
            op1 = wr_data;
        end
        if (wr_hit && (wr_addr == rs2_addr)) begin
            op2 = wr_data;
        end
        stall = rd_en &&
                ((busy_q[rs1_addr] && !(wr_en && (wr_addr == rs1_addr))) ||
                 (busy_q[rs2_addr] && !(wr_en && (wr_addr == rs2_addr))));
`else
        stall = rd_en && (busy_q[rs1_addr] || busy_q[rs2_addr]);
`endif
    end

    assign accept = rd_en && !stall;

    // Read port next state: load on accept, otherwise hold data and drop valid
    always_comb begin
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        rd_valid_d = accept;
        if (accept) begin
            rs1_data_d = op1;
            rs2_data_d = op2;
        end
    end

    // State registers; reset drops all contents and pending busy bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rs1_data = rs1_data_q;
    assign rs2_data = rs2_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_reg_file_rd.sv
// Self-checking bench for reg_file_rd. Expected read results are queued when
// a read is issued and popped when rd_valid is observed.
module tb_reg_file_rd;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            rd_en;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rd_valid;
    logic            stall;
    logic            sb_set;
    logic [4:0]      sb_addr;
    logic            wr_en;
    logic [4:0]      wr_addr;
    logic [XLEN-1:0] wr_data;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
`ifdef RF_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    reg_file_rd #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (rd_en),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_valid (rd_valid),
        .stall    (stall),
        .sb_set   (sb_set),
        .sb_addr  (sb_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0;
        sb_set = 1'b0; sb_addr = 5'd0;
        wr_en = 1'b0; wr_addr = 5'd0; wr_data = '0;
    endtask

    task automatic pop_exp(output exp_t e, output bit ok);
        ok = (exp_q.size() != 0);
        e  = '0;
        if (ok) e = exp_q.pop_front();
    endtask

    task automatic test_reset();
        exp_t e; bit ok;
        idle();
        rst_n = 1'b0;
        #3;
        checks++;
        if (rs1_data !== '0 || rs2_data !== '0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%h v=%b, want 0/0 v=0", rs1_data, rs2_data, rd_valid);
        end
        @(negedge clk); rst_n = 1'b1;
        tick();
        rd_en = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd0;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_read_stall: got %b want 0", stall); end
        exp_q.push_back('{a: 32'h0, b: 32'h0});
        tick();
        idle();
        checks++;
        if (rd_valid !== 1'b1) begin errors++; $display("FAIL reset_read_valid: got %b want 1", rd_valid); end
        pop_exp(e, ok);
        checks++;
        if (!ok || rs1_data !== e.a || rs2_data !== e.b) begin
            errors++; $display("FAIL reset_read_data: got %h/%h want %h/%h", rs1_data, rs2_data, e.a, e.b);
        end
    endtask

    task automatic test_write();
        exp_t e; bit ok;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF;
        tick();
        idle();
        rd_en = 1'b1; rs1_addr = 5'd3;
        exp_q.push_back('{a: 32'hDEADBEEF, b: 32'h0});
        tick();
        idle();
        pop_exp(e, ok);
        checks++;
        if (rd_valid !== 1'b1 || !ok || rs1_data !== e.a || rs2_data !== e.b) begin
            errors++; $display("FAIL write_read: got %h/%h v=%b want %h/%h v=1", rs1_data, rs2_data, rd_valid, e.a, e.b);
        end
        // writes and scoreboard marks to x0 are dropped
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        sb_set = 1'b1; sb_addr = 5'd0;
        tick();
        idle();
        checks++;
        if (rd_valid !== 1'b0 || rs1_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL idle_hold: got %h v=%b want deadbeef v=0", rs1_data, rd_valid);
        end
        rd_en = 1'b1; rs1_addr = 5'd3; rs2_addr = 5'd0;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL x0_stall: got %b want 0", stall); end
        exp_q.push_back('{a: 32'hDEADBEEF, b: 32'h0});
        tick();
        idle();
        pop_exp(e, ok);
        checks++;
        if (rd_valid !== 1'b1 || !ok || rs1_data !== e.a || rs2_data !== e.b) begin
            errors++; $display("FAIL x0_read: got %h/%h v=%b want %h/%h v=1", rs1_data, rs2_data, rd_valid, e.a, e.b);
        end
    endtask

    task automatic test_stall();
        exp_t e; bit ok;
        // same-cycle set does not stall the read issued with it
        sb_set = 1'b1; sb_addr = 5'd7;
        rd_en = 1'b1; rs1_addr = 5'd7; rs2_addr = 5'd3;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL set_same_cycle_stall: got %b want 0", stall); end
        exp_q.push_back('{a: 32'h0, b: 32'hDEADBEEF});
        tick();
        sb_set = 1'b0;
        rs2_addr = 5'd0;
        pop_exp(e, ok);
        checks++;
        if (rd_valid !== 1'b1 || !ok || rs1_data !== e.a || rs2_data !== e.b) begin
            errors++; $display("FAIL set_same_cycle_read: got %h/%h v=%b want %h/%h v=1", rs1_data, rs2_data, rd_valid, e.a, e.b);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (stall !== 1'b1) begin errors++; $display("FAIL busy_stall[%0d]: got %b want 1", i, stall); end
            tick();
            checks++;
            if (rd_valid !== 1'b0 || rs1_data !== 32'h0 || rs2_data !== 32'hDEADBEEF) begin
                errors++; $display("FAIL busy_hold[%0d]: got %h/%h v=%b want 0/deadbeef v=0", i, rs1_data, rs2_data, rd_valid);
            end
        end
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
        #1;
        checks++;
        if (stall !== !BYPASS) begin errors++; $display("FAIL wb_cycle_stall: got %b want %b", stall, !BYPASS); end
        if (!BYPASS) begin
            tick();
            wr_en = 1'b0;
            checks++;
            if (rd_valid !== 1'b0) begin errors++; $display("FAIL wb_cycle_valid: got %b want 0", rd_valid); end
            #1;
            checks++;
            if (stall !== 1'b0) begin errors++; $display("FAIL after_wb_stall: got %b want 0", stall); end
        end
        exp_q.push_back('{a: 32'h55, b: 32'h0});
        tick();
        idle();
        pop_exp(e, ok);
        checks++;
        if (rd_valid !== 1'b1 || !ok || rs1_data !== e.a || rs2_data !== e.b) begin
            errors++; $display("FAIL wb_release_read: got %h/%h v=%b want %h/%h v=1", rs1_data, rs2_data, rd_valid, e.a, e.b);
        end
    endtask

    task automatic test_set_clear_same();
        exp_t e; bit ok;
        sb_set = 1'b1; sb_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5;
        tick();
        idle();
        rd_en = 1'b1; rs1_addr = 5'd0; rs2_addr = 5'd9;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL set_wins_stall: got %b want 1", stall); end
        tick();
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL set_wins_valid: got %b want 0", rd_valid); end
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hB6;
        if (!BYPASS) begin
            tick();
            wr_en = 1'b0;
        end
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL set_wins_release: got %b want 0", stall); end
        exp_q.push_back('{a: 32'h0, b: 32'hB6});
        tick();
        idle();
        pop_exp(e, ok);
        checks++;
        if (rd_valid !== 1'b1 || !ok || rs1_data !== e.a || rs2_data !== e.b) begin
            errors++; $display("FAIL set_wins_read: got %h/%h v=%b want %h/%h v=1", rs1_data, rs2_data, rd_valid, e.a, e.b);
        end
    endtask

    task automatic test_same_cycle_rw();
        exp_t e; bit ok;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h11;
        tick();
        idle();
        rd_en = 1'b1; rs1_addr = 5'd4; rs2_addr = 5'd4;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h77;
        exp_q.push_back(BYPASS ? '{a: 32'h77, b: 32'h77} : '{a: 32'h11, b: 32'h11});
        tick();
        wr_en = 1'b0;
        pop_exp(e, ok);
        checks++;
        if (rd_valid !== 1'b1 || !ok || rs1_data !== e.a || rs2_data !== e.b) begin
            errors++; $display("FAIL rw_same_cycle: got %h/%h v=%b want %h/%h v=1", rs1_data, rs2_data, rd_valid, e.a, e.b);
        end
        // back-to-back read sees the committed value
        exp_q.push_back('{a: 32'h77, b: 32'h77});
        tick();
        idle();
        pop_exp(e, ok);
        checks++;
        if (rd_valid !== 1'b1 || !ok || rs1_data !== e.a || rs2_data !== e.b) begin
            errors++; $display("FAIL back_to_back: got %h/%h v=%b want %h/%h v=1", rs1_data, rs2_data, rd_valid, e.a, e.b);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e; bit ok;
        sb_set = 1'b1; sb_addr = 5'd2;
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        checks++;
        if (rs1_data !== '0 || rs2_data !== '0 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset_clear: got %h/%h v=%b want 0/0 v=0", rs1_data, rs2_data, rd_valid);
        end
        tick();
        rst_n = 1'b1;
        rd_en = 1'b1; rs1_addr = 5'd2; rs2_addr = 5'd4;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL mid_reset_stall: got %b want 0", stall); end
        exp_q.push_back('{a: 32'h0, b: 32'h0});
        tick();
        idle();
        pop_exp(e, ok);
        checks++;
        if (rd_valid !== 1'b1 || !ok || rs1_data !== e.a || rs2_data !== e.b) begin
            errors++; $display("FAIL mid_reset_read: got %h/%h v=%b want %h/%h v=1", rs1_data, rs2_data, rd_valid, e.a, e.b);
        end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        test_reset();
        test_write();
        test_stall();
        test_set_clear_same();
        test_same_cycle_rw();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
